// File: rtl/ahbslv_pkg.sv
// Shared AHB protocol codes and the slave's FSM state type.
package ahbslv_pkg;

  // HTRANS
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_NSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ  = 2'b11;

  // HSIZE
  localparam logic [2:0] HSIZE_B8  = 3'b000;
  localparam logic [2:0] HSIZE_B16 = 3'b001;
  localparam logic [2:0] HSIZE_B32 = 3'b010;

  // HBURST
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  // HRESP
  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_ERR1,
    S_ERR2
  } state_t;

endpackage

// File: rtl/ahbslv_chk.sv
// Address-phase checker: byte lanes and error flag from HADDR/HSIZE.
module ahbslv_chk
  import ahbslv_pkg::*;
#(
  parameter int P_NUM_REGS = 16
) (
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  output logic [3:0]  be,
  output logic        err
);

  // Lane decode plus alignment/size/range checks. The range check uses the
  // whole word offset so that addresses past the implemented window error
  // rather than aliasing onto low words.
  always_comb begin
    be  = 4'b0000;
    err = 1'b0;
    case (size)
      HSIZE_B8:  be = 4'b0001 << addr[1:0];
      HSIZE_B16: begin
        be  = addr[1] ? 4'b1100 : 4'b0011;
        err = addr[0];
      end
      HSIZE_B32: begin
        be  = 4'b1111;
        err = |addr[1:0];
      end
      default:   err = 1'b1;
    endcase
    if ({2'b00, addr[31:2]} >= 32'(P_NUM_REGS)) err = 1'b1;
  end

endmodule

// File: rtl/ahbslv.sv
// AHB slave front end: accepts transfers, inserts wait states, issues the
// two-cycle ERROR response and drives a word-indexed register bus.
module ahbslv
  import ahbslv_pkg::*;
#(
  parameter int P_ADDR_W   = 6,
  parameter int P_NUM_REGS = 16,
  parameter int P_WAIT     = 0
) (
  input  logic                I_AHBSLV_HCLK,
  input  logic                I_AHBSLV_HRESET,
  input  logic                I_AHBSLV_HSEL,
  input  logic [31:0]         I_AHBSLV_HADDR,
  input  logic                I_AHBSLV_HWRITE,
  input  logic [1:0]          I_AHBSLV_HTRANS,
  input  logic [2:0]          I_AHBSLV_HSIZE,
  input  logic [2:0]          I_AHBSLV_HBURST,
  input  logic [31:0]         I_AHBSLV_HWDATA,
  input  logic                I_AHBSLV_HREADY,
  output logic [31:0]         O_AHBSLV_HRDATA,
  output logic                O_AHBSLV_HREADYOUT,
  output logic [1:0]          O_AHBSLV_HRESP,
  output logic [P_ADDR_W-3:0] O_AHBSLV_REG_ADDR,
  output logic [3:0]          O_AHBSLV_REG_BE,
  output logic [31:0]         O_AHBSLV_REG_WDATA,
  output logic                O_AHBSLV_REG_WR,
  output logic                O_AHBSLV_REG_RD,
  input  logic [31:0]         I_AHBSLV_REG_RDATA
);

  localparam logic [1:0] WAIT_LOAD = 2'(P_WAIT - 1);

  state_t state;
  logic [1:0] cnt;
  logic       wr_q;
  logic       accept;
  logic [3:0] be_c;
  logic       err_c;

  // Burst type and the BUSY/SEQ distinction carry no meaning for this slave.
  logic unused_in;
  assign unused_in = ^{I_AHBSLV_HBURST, I_AHBSLV_HTRANS[0]};

  assign accept = I_AHBSLV_HSEL & I_AHBSLV_HREADY & I_AHBSLV_HTRANS[1];

  ahbslv_chk #(.P_NUM_REGS(P_NUM_REGS)) u_chk (
    .addr (I_AHBSLV_HADDR),
    .size (I_AHBSLV_HSIZE),
    .be   (be_c),
    .err  (err_c)
  );

  // Main FSM; every bus/strobe output is registered here. Accepts are only
  // looked at in states where HREADYOUT is high, since otherwise the bus
  // HREADY is low and no address phase can complete.
  always_ff @(posedge I_AHBSLV_HCLK) begin
    if (I_AHBSLV_HRESET) begin
      state              <= S_IDLE;
      cnt                <= 2'd0;
      wr_q               <= 1'b0;
      O_AHBSLV_HREADYOUT <= 1'b1;
      O_AHBSLV_HRESP     <= HRESP_OKAY;
      O_AHBSLV_REG_WR    <= 1'b0;
      O_AHBSLV_REG_RD    <= 1'b0;
      O_AHBSLV_REG_ADDR  <= '0;
      O_AHBSLV_REG_BE    <= 4'b0000;
    end else begin
      O_AHBSLV_REG_WR <= 1'b0;
      O_AHBSLV_REG_RD <= 1'b0;
      case (state)
        S_WAIT: begin
          if (cnt == 2'd0) begin
            state              <= S_ACCESS;
            O_AHBSLV_HREADYOUT <= 1'b1;
            O_AHBSLV_REG_WR    <= wr_q;
            O_AHBSLV_REG_RD    <= ~wr_q;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        S_ERR1: begin
          state              <= S_ERR2;
          O_AHBSLV_HREADYOUT <= 1'b1;
        end
        default: begin
          if (accept) begin
            O_AHBSLV_REG_ADDR <= I_AHBSLV_HADDR[P_ADDR_W-1:2];
            O_AHBSLV_REG_BE   <= be_c;
            wr_q              <= I_AHBSLV_HWRITE;
            if (err_c) begin
              state              <= S_ERR1;
              O_AHBSLV_HREADYOUT <= 1'b0;
              O_AHBSLV_HRESP     <= HRESP_ERROR;
            end else if (P_WAIT > 0) begin
              state              <= S_WAIT;
              cnt                <= WAIT_LOAD;
              O_AHBSLV_HREADYOUT <= 1'b0;
              O_AHBSLV_HRESP     <= HRESP_OKAY;
            end else begin
              state              <= S_ACCESS;
              O_AHBSLV_HREADYOUT <= 1'b1;
              O_AHBSLV_HRESP     <= HRESP_OKAY;
              O_AHBSLV_REG_WR    <= I_AHBSLV_HWRITE;
              O_AHBSLV_REG_RD    <= ~I_AHBSLV_HWRITE;
            end
          end else begin
            state              <= S_IDLE;
            O_AHBSLV_HREADYOUT <= 1'b1;
            O_AHBSLV_HRESP     <= HRESP_OKAY;
          end
        end
      endcase
    end
  end

  // HWDATA is only valid in the data phase, so it is passed through during
  // the write strobe; read data is a full-word pass-through during the read.
  assign O_AHBSLV_REG_WDATA = O_AHBSLV_REG_WR ? I_AHBSLV_HWDATA : 32'h0;
  assign O_AHBSLV_HRDATA    = O_AHBSLV_REG_RD ? I_AHBSLV_REG_RDATA : 32'h0;

endmodule

// File: doc/ahbslv.md
Name: ahbslv

Overview:
AHB slave interface that receives transfers issued by the rotate engine's AHB master, or by any system master, and converts them into a simple word-indexed register-bus access.
- Sits between the AHB interconnect (HSEL/HREADY mux) and a register file or on-chip buffer.
- Checks transfers and generates the AHB response: wait states, OKAY, two-cycle ERROR.
- Single clock; no RETRY/SPLIT support.

Parameters:
P_ADDR_W, 6, byte-offset bits decoded from HADDR (word index = HADDR[P_ADDR_W-1:2])
P_NUM_REGS, 16, number of implemented words; word index >= P_NUM_REGS -> ERROR
P_WAIT, 0, wait states inserted in every OKAY data phase (0..3)

Ports:
I_AHBSLV_HCLK  in  1  clock
I_AHBSLV_HRESET  in  1  reset, synchronous, active-high
I_AHBSLV_HSEL  in  1  slave select from decoder
I_AHBSLV_HADDR  in  32  address
I_AHBSLV_HWRITE  in  1  1=write
I_AHBSLV_HTRANS  in  2  IDLE 00, BUSY 01, NSEQ 10, SEQ 11
I_AHBSLV_HSIZE  in  3  000 byte, 001 half, 010 word
I_AHBSLV_HBURST  in  3  accepted, not used for decode
I_AHBSLV_HWDATA  in  32  write data (data phase)
I_AHBSLV_HREADY  in  1  bus HREADY (mux output)
O_AHBSLV_HRDATA  out  32  read data
O_AHBSLV_HREADYOUT  out  1  slave ready
O_AHBSLV_HRESP  out  2  00 OKAY, 01 ERROR
O_AHBSLV_REG_ADDR  out  P_ADDR_W-2  word index
O_AHBSLV_REG_BE  out  4  byte enables
O_AHBSLV_REG_WDATA  out  32  write data to register file
O_AHBSLV_REG_WR  out  1  write strobe, 1 cycle
O_AHBSLV_REG_RD  out  1  read strobe, 1 cycle
I_AHBSLV_REG_RDATA  in  32  combinational read data for REG_ADDR

Behaviour:
- Reset values: HREADYOUT=1, HRESP=00, HRDATA=0, REG_WR=0, REG_RD=0, REG_ADDR=0, REG_BE=0, REG_WDATA=0, state S_IDLE, wait counter 0.
- Accept condition: address phase accepted on a clock edge where HSEL & HREADY & HTRANS[1].
  - On acceptance, latch HADDR[P_ADDR_W-1:0], HWRITE and HSIZE.
  - Selected IDLE/BUSY, or unselected: zero-wait OKAY, no register access.
- Error check, evaluated at acceptance:
  - HSIZE > 010 -> ERROR.
  - Half with HADDR[0]=1 -> ERROR.
  - Word with HADDR[1:0]!=00 -> ERROR.
  - Word index >= P_NUM_REGS -> ERROR.
- Byte enables:
  - Byte: 4'b0001 << HADDR[1:0].
  - Half: HADDR[1] ? 1100 : 0011.
  - Word: 1111.
- State machine: S_IDLE, S_WAIT, S_ACCESS, S_ERR1, S_ERR2.
  - Accept, ok, P_WAIT>0 -> S_WAIT. Counter loads P_WAIT-1, decrements each cycle, and goes to S_ACCESS at 0. HREADYOUT=0, HRESP=00 throughout.
  - Accept, ok, P_WAIT=0 -> S_ACCESS.
  - Accept, error -> S_ERR1 (HREADYOUT=0, HRESP=01), then S_ERR2 (HREADYOUT=1, HRESP=01). No REG_WR/REG_RD for errored transfers.
  - S_ACCESS: HREADYOUT=1, HRESP=00.
    - Write: REG_WR=1, REG_WDATA=HWDATA, REG_BE from latched lanes.
    - Read: REG_RD=1, HRDATA=REG_RDATA (combinational, full word; master selects lane); HRDATA=0 in all other cycles.
  - From S_ACCESS or S_ERR2: a new accept in the same cycle (pipelined back-to-back) goes to S_WAIT/S_ACCESS/S_ERR1 per rules above; otherwise -> S_IDLE.
  - Back-to-back with P_WAIT=0 sustains one transfer per cycle.
- Latency: write data written at the data-phase completion edge. Read data valid in the final data-phase cycle.
- REG_ADDR always reflects the latched address of the current data phase, never HADDR directly.
- While HREADYOUT=0, new address phases are not sampled, because HREADY is low.
- The master dropping HTRANS to IDLE during S_ERR1 is legal and ignored. A transfer presented during S_ERR2 is accepted normally.
- Reset asserted mid-transfer: pending access discarded, no strobe issued, all outputs at reset values after the edge.

Decomposition:
- Shared include ahb_defs.vh, also used by the AHB master:
  - HTRANS codes: IDLE/BUSY/NSEQ/SEQ.
  - HSIZE codes: B8/B16/B32.
  - HBURST codes: SINGLE/INCR/INCR4/8/16.
  - HRESP codes: OKAY/ERROR.
- One combinational sub-module, ahbslv_chk: HADDR/HSIZE -> byte enables and error flag. The FSM, counter and latches stay in ahbslv.

Test Plan:
1. P_WAIT=0: word write NSEQ addr 0x08, HWDATA 0xDEADBEEF, then read 0x08 -> REG_WR in data phase, ADDR=2, BE=1111; read returns 0xDEADBEEF with HREADYOUT=1 and no wait.
2. P_WAIT=2: half write addr 0x06, HWDATA 0x12341234 -> HREADYOUT low 2 cycles, then REG_WR with BE=1100, HRESP=00.
3. Word read addr 0x0A -> HRESP=01 for 2 cycles, HREADYOUT 0 then 1, no REG_RD. Same for addr 0x40 (index 16) -> ERROR.
4. INCR4 byte writes 0x10..0x13, P_WAIT=0 -> 4 consecutive REG_WR; BE 0001, 0010, 0100, 1000; ADDR=4.
5. HSEL=1 HTRANS=BUSY, then HSEL=0 with HTRANS=NSEQ -> HREADYOUT stays 1, HRESP 00, no strobes.
6. P_WAIT=3 write, HRESET asserted on 2nd wait cycle -> no REG_WR; HREADYOUT=1, HRESP=00, state idle next cycle.
